// File: rtl/instr_mem_loader_if.sv
// Request channel (valid/ready + instruction fields) and byte-wide memory write bus
// between a program source (master) and the instruction memory loader (slave).
interface instr_mem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        instr_sel;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [15:0]       imm;
   logic [25:0]       target;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   modport master (
      output in_valid, instr_sel, rs, rt, rd, shamt, funct, imm, target,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, instr_sel, rs, rt, rd, shamt, funct, imm, target,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_mem_loader.sv
// Encodes instruction requests into 32-bit MIPS words and writes them big-endian,
// one byte per cycle, into byte-addressed instruction memory at an auto-incrementing address.
module instr_mem_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 64,
   parameter int BASE   = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   instr_mem_loader_if.slave            bus,
   output logic [31:0]                  instr_word,
   output logic                         err_illegal,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, WR3} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] base_ptr;
   logic [ADDR_W-1:0] offs;
   logic [5:0]        op;
   logic              legal;
   logic              accept;
   logic [31:0]       enc_word;

   always_comb begin
      op    = 6'b000000;
      legal = 1'b1;
      case (bus.instr_sel)
         4'd0:    op = 6'b000000;
         4'd1:    op = 6'b100011;
         4'd2:    op = 6'b101011;
         4'd3:    op = 6'b101000;
         4'd4:    op = 6'b101001;
         4'd5:    op = 6'b100000;
         4'd6:    op = 6'b100100;
         4'd7:    op = 6'b000100;
         4'd8:    op = 6'b001000;
         4'd9:    op = 6'b001100;
         4'd10:   op = 6'b001101;
         4'd11:   op = 6'b001010;
         4'd12:   op = 6'b000010;
         default: legal = 1'b0;
      endcase
   end

   // Illegal selects fall through to the I-type layout with a zero opcode.
   always_comb begin
      if (bus.instr_sel == 4'd0)
         enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
      else if (bus.instr_sel == 4'd12)
         enc_word = {op, bus.target};
      else
         enc_word = {op, bus.rs, bus.rt, bus.imm};
   end

   assign full         = (int'(count) == DEPTH);
   assign bus.in_ready = rst_n && (state == IDLE) && !full && !clear;
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && legal) state_nxt = WR0;
         WR0:     state_nxt = WR1;
         WR1:     state_nxt = WR2;
         WR2:     state_nxt = WR3;
         WR3:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_we    = 1'b0;
      offs          = '0;
      bus.mem_wdata = 8'h00;
      case (state)
         WR0: begin bus.mem_we = 1'b1; offs = ADDR_W'(0); bus.mem_wdata = instr_word[31:24]; end
         WR1: begin bus.mem_we = 1'b1; offs = ADDR_W'(1); bus.mem_wdata = instr_word[23:16]; end
         WR2: begin bus.mem_we = 1'b1; offs = ADDR_W'(2); bus.mem_wdata = instr_word[15:8];  end
         WR3: begin bus.mem_we = 1'b1; offs = ADDR_W'(3); bus.mem_wdata = instr_word[7:0];   end
         default: ;
      endcase
      bus.mem_addr = base_ptr + offs;
   end

   // clear only takes effect in IDLE so a word in flight always lands completely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_ptr    <= ADDR_W'(BASE);
         count       <= '0;
         instr_word  <= 32'h0;
         err_illegal <= 1'b0;
      end else begin
         err_illegal <= accept && !legal;
         if (accept) instr_word <= enc_word;
         if (state == IDLE && clear) begin
            base_ptr <= ADDR_W'(BASE);
            count    <= '0;
         end else if (state == WR3) begin
            base_ptr <= base_ptr + ADDR_W'(4);
            count    <= count + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized + directed bench for instr_mem_loader: a DEPTH=64 instance for the main
// flow and a DEPTH=2 instance for full/clear behaviour, checked against a word-level model.
module tb_instr_mem_loader;
   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   logic v = 1'b0;
   int   dsel = 0;
   logic [3:0]  f_sel = '0;
   logic [4:0]  f_rs = '0, f_rt = '0, f_rd = '0, f_sh = '0;
   logic [5:0]  f_fn = '0;
   logic [15:0] f_im = '0;
   logic [25:0] f_tg = '0;

   always #5 clk = ~clk;

   instr_mem_loader_if #(.ADDR_W(ADDR_W)) if0 ();
   instr_mem_loader_if #(.ADDR_W(ADDR_W)) if1 ();

   logic [31:0] iw0, iw1;
   logic        err0, err1, full0, full1;
   logic [6:0]  cnt0;
   logic [1:0]  cnt1;

   assign if0.in_valid = v && (dsel == 0);
   assign if1.in_valid = v && (dsel == 1);
   assign if0.instr_sel = f_sel; assign if1.instr_sel = f_sel;
   assign if0.rs = f_rs;         assign if1.rs = f_rs;
   assign if0.rt = f_rt;         assign if1.rt = f_rt;
   assign if0.rd = f_rd;         assign if1.rd = f_rd;
   assign if0.shamt = f_sh;      assign if1.shamt = f_sh;
   assign if0.funct = f_fn;      assign if1.funct = f_fn;
   assign if0.imm = f_im;        assign if1.imm = f_im;
   assign if0.target = f_tg;     assign if1.target = f_tg;

   instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(64), .BASE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .clear(clr && dsel == 0), .bus(if0.slave),
      .instr_word(iw0), .err_illegal(err0), .full(full0), .count(cnt0));

   instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(2), .BASE(0)) u1 (
      .clk(clk), .rst_n(rst_n), .clear(clr && dsel == 1), .bus(if1.slave),
      .instr_word(iw1), .err_illegal(err1), .full(full1), .count(cnt1));

   // Observation mux onto whichever instance is under test
   logic        o_rdy, o_we, o_err, o_full;
   logic [7:0]  o_addr, o_wd;
   logic [31:0] o_iw;
   int          o_cnt;
   always_comb begin
      o_rdy = if0.in_ready; o_we = if0.mem_we; o_addr = if0.mem_addr; o_wd = if0.mem_wdata;
      o_iw = iw0; o_err = err0; o_full = full0; o_cnt = int'(cnt0);
      if (dsel == 1) begin
         o_rdy = if1.in_ready; o_we = if1.mem_we; o_addr = if1.mem_addr; o_wd = if1.mem_wdata;
         o_iw = iw1; o_err = err1; o_full = full1; o_cnt = int'(cnt1);
      end
   end

   logic [7:0] mem_obs [256];
   logic [7:0] mem_exp [256];
   always @(posedge clk) if (if0.mem_we) mem_obs[if0.mem_addr] <= if0.mem_wdata;

   int n_tests = 0, n_fail = 0;
   int exp_addr = 0, exp_cnt = 0;
   logic [31:0] last_word = 32'h0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference encoder built from the opcode table and field bit positions
   function automatic logic [31:0] enc(input int sel, input logic [4:0] rs, rt, rd, sh,
                                       input logic [5:0] fn, input logic [15:0] im,
                                       input logic [25:0] tg);
      logic [5:0] op_tab [13];
      logic [31:0] op;
      op_tab = '{6'o00, 6'o43, 6'o53, 6'o50, 6'o51, 6'o40, 6'o44,
                 6'o04, 6'o10, 6'o14, 6'o15, 6'o12, 6'o02};
      op = (sel <= 12) ? 32'(op_tab[sel]) : 32'h0;
      if (sel == 0)  return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
      if (sel == 12) return (op << 26) | 32'(tg);
      return (op << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(im);
   endfunction

   // Called just after a negedge with the loader idle; returns at a negedge with it idle again.
   task automatic drv_word(input int sel, input logic [4:0] rs, rt, rd, sh,
                           input logic [5:0] fn, input logic [15:0] im,
                           input logic [25:0] tg, input bit keep);
      logic [31:0] w;
      w = enc(sel, rs, rt, rd, sh, fn, im, tg);
      #1;
      chk("ready_before", o_rdy, 1);
      f_sel = 4'(sel); f_rs = rs; f_rt = rt; f_rd = rd; f_sh = sh; f_fn = fn; f_im = im; f_tg = tg;
      v = 1'b1;
      @(negedge clk);
      chk("instr_word", o_iw, w);
      last_word = w;
      if (sel > 12) begin
         chk("err_pulse", o_err, 1);
         chk("ill_no_we", o_we, 0);
         chk("ill_addr", o_addr, 32'(exp_addr));
         v = 1'b0;
         @(negedge clk);
         chk("err_clear", o_err, 0);
         chk("ill_no_we2", o_we, 0);
         chk("ill_count", o_cnt, exp_cnt);
         return;
      end
      chk("err_low", o_err, 0);
      if (!keep) v = 1'b0;
      for (int n = 0; n < 4; n++) begin
         if (n > 0) @(negedge clk);
         chk("we", o_we, 1);
         chk("addr", o_addr, 32'(exp_addr + n));
         chk("wdata", o_wd, 32'(w[31-8*n -: 8]));
         if (dsel == 0) mem_exp[exp_addr + n] = w[31-8*n -: 8];
      end
      @(negedge clk);
      exp_addr += 4; exp_cnt += 1;
      chk("we_idle", o_we, 0);
      chk("addr_idle", o_addr, 32'(exp_addr));
      chk("count", o_cnt, exp_cnt);
      chk("ready_after", o_rdy, (exp_cnt < (dsel ? 2 : 64)) ? 1 : 0);
   endtask

   initial begin
      #3;
      chk("rst_ready", o_rdy, 0);
      chk("rst_we", o_we, 0);
      chk("rst_addr", o_addr, 0);
      chk("rst_wdata", o_wd, 0);
      chk("rst_iw", o_iw, 0);
      chk("rst_err", o_err, 0);
      chk("rst_count", o_cnt, 0);
      chk("rst_full", o_full, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // addi then back-to-back R / lw / j with in_valid held
      drv_word(8, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0, 0);
      chk("addi_word", last_word, 32'h20220005);
      drv_word(0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h0, 26'h0, 1);
      chk("add_word", last_word, 32'h00221820);
      drv_word(1, 5'd0, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0008, 26'h0, 1);
      chk("lw_word", last_word, 32'h8C040008);
      drv_word(12, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10, 0);
      chk("j_word", last_word, 32'h08000010);

      // illegal select, then a legal word at the unchanged address
      drv_word(13, 5'd7, 5'd9, 5'd0, 5'd0, 6'd0, 16'h1234, 26'h0, 0);
      drv_word(10, 5'd3, 5'd5, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'h0, 0);

      // clear and in_valid together: clear wins
      #1;
      clr = 1'b1; v = 1'b1; f_sel = 4'd9; f_rs = 5'd2; f_rt = 5'd6; f_im = 16'hABCD;
      #1;
      chk("clr_ready", o_rdy, 0);
      @(negedge clk);
      chk("clr_count", o_cnt, 0);
      chk("clr_no_we", o_we, 0);
      chk("clr_addr", o_addr, 0);
      chk("clr_iw_kept", o_iw, last_word);
      clr = 1'b0; v = 1'b0;
      exp_addr = 0; exp_cnt = 0;
      drv_word(9, 5'd2, 5'd6, 5'd0, 5'd0, 6'd0, 16'hABCD, 26'h0, 0);

      // reset during WR1 abandons the word
      #1;
      f_sel = 4'd2; f_rs = 5'd8; f_rt = 5'd9; f_im = 16'h0040; v = 1'b1;
      @(negedge clk);
      v = 1'b0;
      @(negedge clk);
      chk("wr1_we", o_we, 1);
      chk("wr1_addr", o_addr, 32'(exp_addr + 1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", o_we, 0);
      chk("mid_rst_addr", o_addr, 0);
      chk("mid_rst_ready", o_rdy, 0);
      chk("mid_rst_count", o_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_addr = 0; exp_cnt = 0;
      drv_word(7, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0, 0);
      chk("beq_word", last_word, 32'h1022FFFF);

      // randomized words, mixing held and dropped in_valid
      for (int i = 0; i < 30; i++)
         drv_word($urandom_range(0, 15), 5'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom),
                  (i < 29) ? bit'($urandom_range(0, 1)) : 1'b0);
      for (int a = 0; a < exp_addr; a++)
         chk("mem_image", 32'(mem_obs[a]), 32'(mem_exp[a]));

      // DEPTH=2 instance: fill, hold off, clear, then the held request lands at BASE
      dsel = 1; exp_addr = 0; exp_cnt = 0;
      @(negedge clk);
      drv_word(8, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'h0, 0);
      drv_word(11, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'h0, 0);
      chk("d2_full", o_full, 1);
      chk("d2_ready", o_rdy, 0);
      #1;
      f_sel = 4'd6; f_rs = 5'd4; f_rt = 5'd5; f_im = 16'h0003; v = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("d2_held_we", o_we, 0);
         chk("d2_held_cnt", o_cnt, 2);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_addr = 0; exp_cnt = 0;
      chk("d2_clr_full", o_full, 0);
      chk("d2_clr_cnt", o_cnt, 0);
      drv_word(6, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0003, 26'h0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Encoder/writer counterpart to the opcode decoder in the datapath: accepts instruction requests (instruction select plus fields) over a valid/ready handshake.
- Assembles each request into a 32-bit MIPS instruction word using the datapath's opcode map.
- Writes the word byte-serially, big-endian, into the byte-addressed instruction memory at an auto-incrementing address.
- Used by benches and boot logic to load programs without hand-coded hex files.

Parameters:
ADDR_W, 8, instruction memory byte-address width
DEPTH, 64, maximum number of words loaded before full; DEPTH*4 must be <= 2**ADDR_W
BASE, 0, byte address of first word; multiple of 4

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous restart: address back to BASE, count to 0
in_valid  input  1  request present
in_ready  output  1  loader can accept a request
instr_sel  input  4  0=R-type, 1=lw, 2=sw, 3=sb, 4=sh, 5=lb, 6=lbu, 7=beq, 8=addi, 9=andi, 10=ori, 11=slti, 12=j, 13-15 illegal
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register (R-type only)
shamt  input  5  shift amount (R-type only)
funct  input  6  function code (R-type only)
imm  input  16  immediate/offset (I-type)
target  input  26  jump target (j)
mem_we  output  1  byte write strobe
mem_addr  output  ADDR_W  byte address
mem_wdata  output  8  byte data
instr_word  output  32  last accepted encoded word
err_illegal  output  1  one-cycle pulse on illegal instr_sel accept
full  output  1  count == DEPTH
count  output  $clog2(DEPTH+1)  words written

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=0 while rst_n low, mem_we=0, mem_addr=BASE, mem_wdata=0, instr_word=0, err_illegal=0, count=0, full=0.
- Opcodes:
  - R 000000; lw 100011; sw 101011; sb 101000; sh 101001; lb 100000; lbu 100100.
  - beq 000100; addi 001000; andi 001100; ori 001101; slti 001010; j 000010.
- Encoding:
  - R-type: {6'b0, rs, rt, rd, shamt, funct}.
  - I-type (sel 1-11): {op, rs, rt, imm}.
  - J-type: {op, target}.
  - Fields unused by a format are ignored.
- in_ready = (state==IDLE) && !full && !clear.
- Accept = in_valid && in_ready.
  - instr_word is registered on the accept edge, including for illegal selects (opcode field 0 for illegal).
- Illegal select accepted:
  - err_illegal=1 for the next cycle only.
  - No write; state stays IDLE; address and count are unchanged.
- Legal select accepted: state goes to WR0, WR1, WR2, WR3, one cycle each.
  - In WRn: mem_we=1, mem_addr=base_ptr+n, mem_wdata=instr_word[31-8n -: 8] (MSB first).
  - On leaving WR3: base_ptr += 4, count += 1, state returns to IDLE.
  - Throughput: one word per 5 cycles; in_ready is high again the cycle after WR3.
- Outside WRn: mem_we=0, mem_addr holds base_ptr.
- full = (count==DEPTH).
  - While full, in_ready=0 and requests are held off (not dropped).
  - Only clear or reset leaves full.
- Address arithmetic is ADDR_W bits and cannot wrap under the DEPTH constraint.
- clear:
  - Acts only in IDLE: base_ptr=BASE, count=0, full=0 next cycle.
  - clear with in_valid in the same cycle: clear wins, request not accepted.
  - clear during WRn is ignored; the word completes.
- Reset mid-write: outputs go to reset values immediately; the partial word is abandoned; the next load starts at BASE.
- in_valid is don't-care when in_ready=0.
- Request fields need only be stable in the accept cycle.

Test Plan:
- addi: sel=8, rs=1, rt=2, imm=16'h0005 -> instr_word=32'h20220005; bytes 20,22,00,05 written at addr 0,1,2,3 in 4 consecutive cycles; count=1; in_ready high on the 5th cycle after accept.
- Back-to-back words with in_valid held high:
  - R-type add: rs=1, rt=2, rd=3, shamt=0, funct=6'b100000 -> 32'h00221820 at addr 4-7.
  - lw: rs=0, rt=4, imm=8 -> 32'h8C040008 at addr 8-11.
  - j: target=26'h10 -> 32'h08000010 at addr 12-15.
  - Each word completes in 5 cycles with no dropped requests.
- Illegal sel=13 -> err_illegal single-cycle pulse, mem_we never asserted, mem_addr and count unchanged, next legal word lands at the unchanged address.
- DEPTH=2 instance: after 2 words full=1, in_ready=0, a third in_valid is held off; pulse clear -> full=0, count=0, next word written at BASE.
- Reset asserted during WR1 -> mem_we=0 and mem_addr=BASE without waiting for a clock edge; after release, sel=7 (beq), rs=1, rt=2, imm=16'hFFFF -> 32'h1022FFFF at addr 0-3.
- clear and in_valid high in the same IDLE cycle -> request not accepted, count=0; request accepted on the following cycle.
